// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin burst arbiter sharing one FIFO write port among NREQ requesters.
//   One bubble cycle per arbitration, bursts of up to BURST words, zero-latency
//   handshake-to-write path, and wr_full backpressure that holds the grant.
//   Optional feature macro: FIFO_ARB_STAT_EN (per-requester accepted-word counters).
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DBITS = 16,
  parameter int BURST = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DBITS-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wr_full,
  output logic                    wr_en,
  output logic [DBITS-1:0]        wr_data,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic [NREQ*32-1:0]      stat_words
);

  localparam int IDW  = $clog2(NREQ);
  localparam int CNTW = $clog2(BURST + 1);
  localparam logic [IDW-1:0]  LAST_ID   = IDW'(NREQ - 1);
  localparam logic [CNTW-1:0] BEAT_LAST = CNTW'(BURST - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [IDW-1:0]  grant_id_r;
  logic [IDW-1:0]  grant_nxt_s;
  logic [CNTW-1:0] beat_r;
  logic [CNTW-1:0] beat_nxt_s;

  logic             sel_valid_s;
  logic [DBITS-1:0] sel_data_s;
  logic             in_grant_s;
  logic             xfer_s;

  // First valid requester after 'last', wrapping; returns 'last' when none valid.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0] pick;
    logic           found;
    int             idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && valid[idx]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  assign sel_valid_s = req_valid[grant_id_r];
  assign sel_data_s  = req_data[grant_id_r*DBITS +: DBITS];
  // The reset cycle itself must never issue a write, hence the ~rst term.
  assign in_grant_s  = (state_r == ST_GRANT) && !rst;
  assign xfer_s      = in_grant_s && sel_valid_s && !wr_full;

  // Granted requester drives the FIFO write port; everything idles otherwise.
  always_comb begin
    req_ready = '0;
    wr_en     = 1'b0;
    wr_data   = '0;
    if (in_grant_s) begin
      req_ready[grant_id_r] = ~wr_full;
      wr_en                 = sel_valid_s & ~wr_full;
      wr_data               = sel_data_s;
    end else begin
      wr_en = 1'b0;
    end
  end

  // Arbitration in IDLE, burst counting and release decisions in GRANT.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_id_r;
    beat_nxt_s  = beat_r;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid) begin
          state_nxt_s = ST_GRANT;
          grant_nxt_s = rr_pick(req_valid, grant_id_r);
          beat_nxt_s  = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (xfer_s) begin
          beat_nxt_s = beat_r + CNTW'(1);
        end else begin
          beat_nxt_s = beat_r;
        end
        // A dropped valid releases the grant even while wr_full is high.
        if (!sel_valid_s) begin
          state_nxt_s = ST_IDLE;
        end else if (xfer_s && (beat_r == BEAT_LAST)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, grant and beat registers; reset leaves grant_id at NREQ-1 so req 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      grant_id_r <= LAST_ID;
      beat_r     <= '0;
    end else begin
      state_r    <= state_nxt_s;
      grant_id_r <= grant_nxt_s;
      beat_r     <= beat_nxt_s;
    end
  end

  assign grant_id = grant_id_r;
  assign busy     = (state_r == ST_GRANT);

`ifdef FIFO_ARB_STAT_EN
  logic [NREQ*32-1:0] stat_r;

  // Per-requester accepted-word counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_r <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (xfer_s && (grant_id_r == IDW'(i))) begin
          stat_r[i*32 +: 32] <= stat_r[i*32 +: 32] + 32'd1;
        end else begin
          stat_r[i*32 +: 32] <= stat_r[i*32 +: 32];
        end
      end
    end
  end

  assign stat_words = stat_r;
`else
  assign stat_words = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed scenarios for fifo_wr_arbiter (NREQ=4, DBITS=16, BURST=8).
//   Requester i sends words base[i]+1, base[i]+2, ... ; expected values are hand-derived.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DBITS = 16;
  localparam int BURST = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DBITS-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wr_full;
  logic                  wr_en;
  logic [DBITS-1:0]      wr_data;
  logic [1:0]            grant_id;
  logic                  busy;
  logic [NREQ*32-1:0]    stat_words;

  int checks = 0;
  int passes = 0;
  int sent  [NREQ];
  int total [NREQ];
  int base  [NREQ];

  fifo_wr_arbiter #(.NREQ(NREQ), .DBITS(DBITS), .BURST(BURST)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wr_full    (wr_full),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .grant_id   (grant_id),
    .busy       (busy),
    .stat_words (stat_words)
  );

  always #5 clk = ~clk;

  // One cycle: drive at negedge from the producer model, settle, record handshakes.
  task automatic step(input logic full, input logic reset);
    @(negedge clk);
    rst     = reset;
    wr_full = full;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (sent[i] < total[i]);
      req_data[i*DBITS +: DBITS] = DBITS'(base[i] + sent[i] + 1);
    end
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) sent[i] = sent[i] + 1;
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < NREQ; i++) begin
      sent[i] = 0; total[i] = 0; base[i] = i * 1000;
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b0, 1'b0);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passes++;
    checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %0b want 0", wr_en); else passes++;
    checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", req_ready); else passes++;
    checks++; if (wr_data !== 16'd0) $display("FAIL reset_wr_data got %0d want 0", wr_data); else passes++;
    checks++; if (grant_id !== 2'd3) $display("FAIL reset_grant got %0d want 3", grant_id); else passes++;
    checks++; if (stat_words !== 128'd0) $display("FAIL reset_stat got %h want 0", stat_words); else passes++;
  endtask

  // Req 0 alone, 20 words: bursts of 8, 8, 4 with one idle cycle between.
  task automatic test_single_req();
    int   exp_word;
    logic exp_en;
    do_reset();
    total[0] = 20;
    exp_word = 1;
    for (int c = 0; c < 25; c++) begin
      step(1'b0, 1'b0);
      exp_en = (c >= 1 && c <= 8) || (c >= 10 && c <= 17) || (c >= 19 && c <= 22);
      checks++; if (wr_en !== exp_en) $display("FAIL single_wr_en c=%0d got %0b want %0b", c, wr_en, exp_en); else passes++;
      if (exp_en) begin
        checks++; if (wr_data !== 16'(exp_word)) $display("FAIL single_data c=%0d got %0d want %0d", c, wr_data, exp_word); else passes++;
        exp_word++;
      end
      if (c >= 1) begin
        checks++; if (grant_id !== 2'd0) $display("FAIL single_grant c=%0d got %0d want 0", c, grant_id); else passes++;
      end
      if (c == 24) begin
        checks++; if (busy !== 1'b0) $display("FAIL single_end_busy got %0b want 0", busy); else passes++;
      end
    end
    checks++; if (sent[0] !== 20) $display("FAIL single_count got %0d want 20", sent[0]); else passes++;
  endtask

  // All four always valid, 64 words each: order 0,1,2,3,... with 9-cycle burst slots.
  task automatic test_round_robin();
    int         k;
    int         ph;
    int         g;
    logic [3:0] exp_rdy;
    do_reset();
    for (int i = 0; i < NREQ; i++) total[i] = 64;
    for (int c = 0; c <= 288; c++) begin
      step(1'b0, 1'b0);
      k  = c / 9;
      ph = c % 9;
      g  = k % 4;
      exp_rdy = (ph != 0) ? (4'b0001 << g) : 4'b0000;
      checks++; if (wr_en !== (ph != 0)) $display("FAIL rr_wr_en c=%0d got %0b want %0b", c, wr_en, ph != 0); else passes++;
      checks++; if (req_ready !== exp_rdy) $display("FAIL rr_ready c=%0d got %b want %b", c, req_ready, exp_rdy); else passes++;
      if (ph != 0) begin
        checks++; if (grant_id !== 2'(g)) $display("FAIL rr_grant c=%0d got %0d want %0d", c, grant_id, g); else passes++;
        checks++; if (wr_data !== 16'(g*1000 + (k/4)*8 + ph)) $display("FAIL rr_data c=%0d got %0d want %0d", c, wr_data, g*1000 + (k/4)*8 + ph); else passes++;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
`ifdef FIFO_ARB_STAT_EN
      checks++; if (stat_words[i*32 +: 32] !== 32'd64) $display("FAIL rr_stat%0d got %0d want 64", i, stat_words[i*32 +: 32]); else passes++;
`else
      checks++; if (stat_words[i*32 +: 32] !== 32'd0) $display("FAIL rr_stat%0d got %0d want 0", i, stat_words[i*32 +: 32]); else passes++;
`endif
    end
  endtask

  // Req 1 burst with wr_full high for 5 cycles after its third word.
  task automatic test_backpressure();
    logic full;
    logic exp_en;
    int   exp_word;
    do_reset();
    total[1] = 8;
    exp_word = 1;
    for (int c = 0; c <= 14; c++) begin
      full = (c >= 4 && c <= 8);
      step(full, 1'b0);
      exp_en = (c >= 1 && c <= 3) || (c >= 9 && c <= 13);
      checks++; if (wr_en !== exp_en) $display("FAIL bp_wr_en c=%0d got %0b want %0b", c, wr_en, exp_en); else passes++;
      checks++; if (req_ready !== (exp_en ? 4'b0010 : 4'b0000)) $display("FAIL bp_ready c=%0d got %b want %b", c, req_ready, exp_en ? 4'b0010 : 4'b0000); else passes++;
      if (c >= 1) begin
        checks++; if (grant_id !== 2'd1) $display("FAIL bp_grant c=%0d got %0d want 1", c, grant_id); else passes++;
      end
      if (full) begin
        checks++; if (busy !== 1'b1) $display("FAIL bp_busy c=%0d got %0b want 1", c, busy); else passes++;
      end
      if (exp_en) begin
        checks++; if (wr_data !== 16'(1000 + exp_word)) $display("FAIL bp_data c=%0d got %0d want %0d", c, wr_data, 1000 + exp_word); else passes++;
        exp_word++;
      end
    end
    checks++; if (busy !== 1'b0) $display("FAIL bp_end_busy got %0b want 0", busy); else passes++;
    checks++; if (sent[1] !== 8) $display("FAIL bp_count got %0d want 8", sent[1]); else passes++;
  endtask

  // Req 2 drops valid after 3 words; req 3 granted two cycles after the drop.
  task automatic test_valid_drop();
    logic exp_en;
    int   exp_d;
    int   exp_g;
    do_reset();
    total[2] = 3;
    total[3] = 4;
    for (int c = 0; c <= 10; c++) begin
      step(1'b0, 1'b0);
      exp_en = (c >= 1 && c <= 3) || (c >= 6 && c <= 9);
      exp_d  = (c <= 3) ? 2000 + c : 3000 + c - 5;
      exp_g  = (c >= 6) ? 3 : 2;
      checks++; if (wr_en !== exp_en) $display("FAIL drop_wr_en c=%0d got %0b want %0b", c, wr_en, exp_en); else passes++;
      if (c >= 1) begin
        checks++; if (grant_id !== 2'(exp_g)) $display("FAIL drop_grant c=%0d got %0d want %0d", c, grant_id, exp_g); else passes++;
      end
      if (exp_en) begin
        checks++; if (wr_data !== 16'(exp_d)) $display("FAIL drop_data c=%0d got %0d want %0d", c, wr_data, exp_d); else passes++;
      end
      if (c == 4 || c == 5) begin
        checks++; if (busy !== (c == 4)) $display("FAIL drop_busy c=%0d got %0b want %0b", c, busy, c == 4); else passes++;
      end
    end
  endtask

  // rst pulsed mid-burst: burst truncated, arbitration restarts at req 0.
  task automatic test_reset_mid_burst();
    do_reset();
    total[0] = 20;
    for (int c = 0; c <= 6; c++) begin
      step(1'b0, c == 4);
      if (c >= 1 && c <= 3) begin
        checks++; if (wr_data !== 16'(c) || wr_en !== 1'b1) $display("FAIL mid_pre c=%0d got en=%0b data=%0d want en=1 data=%0d", c, wr_en, wr_data, c); else passes++;
      end
      if (c == 4) begin
        checks++; if (wr_en !== 1'b0) $display("FAIL mid_rst_cycle_wr_en got %0b want 0", wr_en); else passes++;
      end
      if (c == 5) begin
        checks++; if (busy !== 1'b0 || wr_en !== 1'b0 || grant_id !== 2'd3) $display("FAIL mid_after got busy=%0b en=%0b grant=%0d want busy=0 en=0 grant=3", busy, wr_en, grant_id); else passes++;
      end
      if (c == 6) begin
        checks++; if (grant_id !== 2'd0 || wr_en !== 1'b1 || wr_data !== 16'd4) $display("FAIL mid_rearb got grant=%0d en=%0b data=%0d want grant=0 en=1 data=4", grant_id, wr_en, wr_data); else passes++;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    wr_full   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    test_reset();
    test_single_req();
    test_round_robin();
    test_backpressure();
    test_valid_drop();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin burst arbiter that shares the single write port of a FIFO (bfm_fifo_async write side) among NREQ requesters.
- Sits in the FIFO write-clock domain, between producer blocks and the FIFO's wr_data/wr_en/wr_full.
- Grants one requester at a time for bursts of up to BURST words and honours wr_full backpressure with zero data loss.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DBITS, 16, data width per requester and of wr_data.
- BURST, 8, maximum words per grant before forced re-arbitration (1..256).

Ports:
- clk  input  1  clock; connect to the FIFO wr_clk.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester word valid.
- req_data  input  NREQ*DBITS  requester i data in bits [i*DBITS +: DBITS].
- req_ready  output  NREQ  per-requester word accepted; a transfer occurs when valid and ready are both high.
- wr_full  input  1  FIFO full flag.
- wr_en  output  1  FIFO write enable.
- wr_data  output  DBITS  FIFO write data.
- grant_id  output  clog2(NREQ)  index of the current or last granted requester.
- busy  output  1  high while in GRANT.
- stat_words  output  NREQ*32  per-requester accepted-word counters (see Optional Feature).

Behaviour:
- Single clock. rst is sampled on the clk edge only.
- Reset values:
  - state = IDLE; busy = 0; req_ready = 0; wr_en = 0; wr_data = 0.
  - grant_id = NREQ-1, so requester 0 wins first; beat counter = 0; stat_words = 0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req_valid is high, select the first requester with valid set, searching from (grant_id+1) mod NREQ upward with wrap.
  - Register the winner into grant_id, clear the beat counter, and move to GRANT on the next cycle.
  - This gives exactly one bubble cycle per arbitration.
  - If no valid is set, stay in IDLE; grant_id holds.
- GRANT, combinational outputs:
  - req_ready[grant_id] = ~wr_full; all other ready bits = 0.
  - wr_en = req_valid[grant_id] & ~wr_full.
  - wr_data = req_data of grant_id while in GRANT; 0 otherwise.
  - Write latency is 0 cycles from requester handshake to FIFO write.
- GRANT, beat counting and exit:
  - Each transfer increments the beat counter, which is wide enough to hold BURST.
  - A transfer that brings the count to BURST returns the FSM to IDLE on the next cycle.
  - A cycle in GRANT with req_valid[grant_id] = 0 returns the FSM to IDLE on the next cycle, even if the count is below BURST.
- wr_full high in GRANT:
  - No transfer, and the beat counter holds.
  - The grant is held indefinitely; wr_full alone never releases it.
  - The transfer resumes in the first cycle wr_full is low.
- Simultaneous events:
  - If valid drops while wr_full is high, valid=0 is the release cause and the FSM goes to IDLE.
  - Non-granted requesters only wait; their valid may toggle freely.
- Fairness: the requester just served gets lowest priority at the next arbitration. Worst-case wait is (NREQ-1)*(BURST+1) active cycles plus full stalls.
- Reset mid-burst: the FSM returns to IDLE next cycle with all reset values. Any partially transferred burst is simply truncated; no write is issued in the reset cycle.
- wr_en is never high while wr_full is high, so the arbiter can never overflow the FIFO.

Optional Feature:
- Macro: FIFO_ARB_STAT_EN.
- Defined:
  - stat_words slice i increments by 1 on every accepted word from requester i.
  - Each slice wraps modulo 2^32 and clears on rst.
- Undefined:
  - No counter logic is built; stat_words is tied to 0.
  - All other behaviour is identical.

Test Plan:
- Only req 0 valid, 20 words, BURST=8, wr_full=0 -> wr_en runs in bursts of 8, 8, 4 with a 1-cycle low gap between bursts; wr_data follows sequence 1..20; grant_id stays 0.
- All 4 requesters continuously valid, each sending sequence i*1000+n -> grant order 0,1,2,3,0,...; each burst is exactly 8 words; one bubble per switch; per-requester sequences arrive unbroken.
- wr_full forced high for 5 cycles after word 3 of req 1's burst -> wr_en=0 and req_ready=0 for those 5 cycles; grant_id holds at 1; 5 more words follow; no loss or duplicate.
- Req 2 drops valid after 3 words while req 3 is valid -> FSM returns to IDLE; req 3 is granted 2 cycles after the drop.
- rst pulsed 1 cycle in the middle of a burst -> next cycle busy=0, wr_en=0, grant_id=NREQ-1; first arbitration after reset picks req 0.
- With FIFO_ARB_STAT_EN defined, run scenario 2 for 64 words per requester -> every stat_words slice reads 64. With the macro undefined -> all slices read 0.
